// File: rtl/bus_copy_pkg.sv
// rtl/bus_copy_pkg.sv - shared types and constants for the bus copy master
package bus_copy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0]  BE_FULL   = 4'hF;
    localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/copy_fifo.sv
// rtl/copy_fifo.sv - small synchronous FIFO holding read data awaiting write-back
module copy_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bus_copy_master.sv
// rtl/bus_copy_master.sv - word copy initiator overlapping buffered reads and writes on one bus
module bus_copy_master
    import bus_copy_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_bi,
    input  logic [31:0]      dst_addr_bi,
    input  logic [LEN_W-1:0] len_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [31:0]      bus_addr_bo,
    output logic [3:0]       bus_be_bo,
    output logic [31:0]      bus_wdata_bo,
    input  logic             bus_ack_i,
    input  logic             bus_resp_i,
    input  logic [31:0]      bus_rdata_bi
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t           state, state_n;
    logic [31:0]      rd_addr, rd_addr_n, wr_addr, wr_addr_n;
    logic [LEN_W-1:0] rd_left, rd_left_n, wr_left, wr_left_n;
    logic [CW-1:0]    outstanding, outstanding_n;
    logic [CW-1:0]    fifo_count, cnt_n;
    logic             req_q, req_n, we_q, we_n;
    logic [31:0]      addr_q, addr_n;
    logic             rd_acc, wr_acc, resp_ok, credit_ok;
    logic [31:0]      fifo_dout;
    logic             fifo_full, fifo_empty;
    logic             unused_bits;

    assign rd_acc  = req_q && bus_ack_i && !we_q;
    assign wr_acc  = req_q && bus_ack_i && we_q;
    // A response with nothing in flight is a leftover from before a reset.
    assign resp_ok = bus_resp_i && (outstanding != '0);

    copy_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (resp_ok),
        .din   (bus_rdata_bi),
        .pop   (wr_acc),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n       = state;
        rd_addr_n     = rd_addr;
        wr_addr_n     = wr_addr;
        rd_left_n     = rd_left;
        wr_left_n     = wr_left;
        req_n         = req_q;
        we_n          = we_q;
        addr_n        = addr_q;
        cnt_n         = fifo_count + CW'(resp_ok) - CW'(wr_acc);
        outstanding_n = outstanding + CW'(rd_acc) - CW'(resp_ok);
        credit_ok     = ({1'b0, cnt_n} + {1'b0, outstanding_n}) < (CW + 1)'(FIFO_DEPTH);

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n   = RUN;
                    rd_addr_n = {src_addr_bi[31:2], 2'b00};
                    wr_addr_n = {dst_addr_bi[31:2], 2'b00};
                    rd_left_n = len_bi;
                    wr_left_n = len_bi;
                end
            end
            RUN: begin
                if (rd_acc) begin
                    rd_addr_n = rd_addr + ADDR_STEP;
                    rd_left_n = rd_left - 1'b1;
                end
                if (wr_acc) begin
                    wr_addr_n = wr_addr + ADDR_STEP;
                    wr_left_n = wr_left - 1'b1;
                end
                // Decisions use post-cycle counts so a new request can follow an ack without a bubble.
                if (wr_left_n == '0) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    addr_n  = '0;
                end else if (!req_q || bus_ack_i) begin
                    if (cnt_n != '0) begin
                        req_n  = 1'b1;
                        we_n   = 1'b1;
                        addr_n = wr_addr_n;
                    end else if (rd_left_n != '0 && credit_ok) begin
                        req_n  = 1'b1;
                        we_n   = 1'b0;
                        addr_n = rd_addr_n;
                    end else begin
                        req_n  = 1'b0;
                        we_n   = 1'b0;
                        addr_n = '0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rd_addr     <= '0;
            wr_addr     <= '0;
            rd_left     <= '0;
            wr_left     <= '0;
            outstanding <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
        end else begin
            state       <= state_n;
            rd_addr     <= rd_addr_n;
            wr_addr     <= wr_addr_n;
            rd_left     <= rd_left_n;
            wr_left     <= wr_left_n;
            outstanding <= outstanding_n;
            req_q       <= req_n;
            we_q        <= we_n;
            addr_q      <= addr_n;
        end
    end

    assign busy_o       = (state == RUN);
    assign done_o       = (state == DONE);
    assign bus_req_o    = req_q;
    assign bus_we_o     = we_q;
    assign bus_addr_bo  = addr_q;
    assign bus_be_bo    = req_q ? BE_FULL : 4'h0;
    assign bus_wdata_bo = we_q ? fifo_dout : 32'h0;

    assign unused_bits = ^{src_addr_bi[1:0], dst_addr_bi[1:0], fifo_full, fifo_empty};

endmodule

// File: tb/tb_bus_copy_master.sv
// tb/tb_bus_copy_master.sv - randomized copy transfers against a transfer-level reference model
module tb_bus_copy_master;

    localparam int DEPTH = 2;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr, dst_addr;
    logic [LEN_W-1:0] len_b;
    logic             busy, done;
    logic             bus_req, bus_we;
    logic [31:0]      bus_addr, bus_wdata;
    logic [3:0]       bus_be;
    logic             bus_ack, bus_resp;
    logic [31:0]      bus_rdata;

    always #5 clk = ~clk;

    bus_copy_master #(
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src_addr_bi  (src_addr),
        .dst_addr_bi  (dst_addr),
        .len_bi       (len_b),
        .busy_o       (busy),
        .done_o       (done),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_bo  (bus_addr),
        .bus_be_bo    (bus_be),
        .bus_wdata_bo (bus_wdata),
        .bus_ack_i    (bus_ack),
        .bus_resp_i   (bus_resp),
        .bus_rdata_bi (bus_rdata)
    );

    int n_checks = 0;
    int n_err    = 0;

    int unsigned mem [int unsigned];
    logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
    logic [31:0] rlog[$], wlog_a[$], wlog_d[$];
    int exp_len, rd_n, wr_n, inflight, done_cnt, cyc;
    bit mon_en;
    int stall_cfg, lat_cfg, stall_cnt;
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    resp_t rq[$];
    bit          prev_pend;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %h expected none", nm, act);
    endtask

    function automatic logic [31:0] src_data(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Responder and per-cycle checker; everything happens at the falling edge.
    initial begin
        bit acc;
        bus_ack   = 1'b0;
        bus_resp  = 1'b0;
        bus_rdata = '0;
        stall_cnt = 0;
        cyc       = 0;
        prev_pend = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus_ack = bus_req && (stall_cnt >= stall_cfg);
            acc     = bus_req && bus_ack && !rst;
            if (done && !rst) done_cnt++;
            if (mon_en && !rst) begin
                if (bus_req) check("be", 32'(bus_be), 32'hF);
                if (!busy && !done) check("idle_req", 32'(bus_req), 32'h0);
                if (prev_pend) begin
                    check("stall_req", 32'(bus_req), 32'h1);
                    check("stall_we", 32'(bus_we), 32'(prev_we));
                    check("stall_addr", bus_addr, prev_addr);
                    if (prev_we) check("stall_wdata", bus_wdata, prev_wdata);
                end
                if (acc && !bus_we) begin
                    if (rd_n < exp_len) check("rd_addr", bus_addr, exp_rd[rd_n]);
                    else fail("extra_read", bus_addr);
                    rlog.push_back(bus_addr);
                    rd_n++;
                    inflight++;
                    check("credit", 32'(inflight <= DEPTH), 32'h1);
                end else if (acc) begin
                    if (wr_n < exp_len) begin
                        check("wr_addr", bus_addr, exp_wa[wr_n]);
                        check("wr_data", bus_wdata, exp_wd[wr_n]);
                    end else begin
                        fail("extra_write", bus_addr);
                    end
                    wlog_a.push_back(bus_addr);
                    wlog_d.push_back(bus_wdata);
                    wr_n++;
                    inflight--;
                end
                if (done) begin
                    check("done_all_written", 32'(wr_n), 32'(exp_len));
                    check("done_busy", 32'(busy), 32'h0);
                end
            end
            if (acc && !bus_we) rq.push_back('{cyc + lat_cfg, src_data(bus_addr)});
            prev_pend  = bus_req && !acc && !rst;
            prev_we    = bus_we;
            prev_addr  = bus_addr;
            prev_wdata = bus_wdata;
            stall_cnt  = acc ? 0 : (bus_req ? stall_cnt + 1 : 0);
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus_resp  = 1'b1;
                bus_rdata = rq[0].data;
                void'(rq.pop_front());
            end else begin
                bus_resp  = 1'b0;
                bus_rdata = $urandom;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic setup_model(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] s, d;
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        rlog.delete();
        wlog_a.delete();
        wlog_d.delete();
        for (int i = 0; i < len; i++) begin
            exp_rd.push_back(s + 32'(4 * i));
            exp_wa.push_back(d + 32'(4 * i));
            exp_wd.push_back(src_data(s + 32'(4 * i)));
        end
        exp_len  = len;
        rd_n     = 0;
        wr_n     = 0;
        inflight = 0;
        mon_en   = 1'b1;
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int stall, input int lat, input bit poke);
        int d0, n;
        stall_cfg = stall;
        lat_cfg   = lat;
        setup_model(src, dst, len);
        d0       = done_cnt;
        src_addr = src;
        dst_addr = dst;
        len_b    = LEN_W'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len_b    = LEN_W'($urandom);
        check("busy_after_start", 32'(busy), 32'h1);
        check("no_req_cycle1", 32'(bus_req), 32'h0);
        tick();
        if (len > 0) begin
            check("first_req", 32'(bus_req), 32'h1);
            check("first_req_we", 32'(bus_we), 32'h0);
            check("first_req_addr", bus_addr, exp_rd[0]);
        end else begin
            check("len0_done", 32'(done), 32'h1);
            check("len0_req", 32'(bus_req), 32'h0);
        end
        if (poke) begin
            start = 1'b1;
            len_b = 16'd1;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            tick();
            n++;
        end
        if (done_cnt == d0) fail("timeout", 32'(n));
        tick();
        tick();
        check("done_once", 32'(done_cnt - d0), 32'h1);
        check("busy_end", 32'(busy), 32'h0);
        check("reads_total", 32'(rd_n), 32'(len));
        check("writes_total", 32'(wr_n), 32'(len));
    endtask

    initial begin
        int n, d0;
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_b     = '0;
        mon_en    = 1'b0;
        stall_cfg = 0;
        lat_cfg   = 1;
        done_cnt  = 0;
        exp_len   = 0;
        repeat (3) tick();
        check("rst_req", 32'(bus_req), 32'h0);
        check("rst_we", 32'(bus_we), 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_be", 32'(bus_be), 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        tick();

        mem[32'h100] = 32'hA;
        mem[32'h104] = 32'hB;
        mem[32'h108] = 32'hC;
        mem[32'h10C] = 32'hD;
        run_copy(32'h100, 32'h200, 4, 0, 1, 1'b0);
        check("t1_nwrites", 32'(wlog_a.size()), 32'd4);
        if (wlog_a.size() == 4) begin
            check("t1_d0", wlog_d[0], 32'hA);
            check("t1_d1", wlog_d[1], 32'hB);
            check("t1_d2", wlog_d[2], 32'hC);
            check("t1_d3", wlog_d[3], 32'hD);
            check("t1_a0", wlog_a[0], 32'h200);
            check("t1_a3", wlog_a[3], 32'h20C);
        end

        run_copy(32'h500, 32'h600, 0, 0, 1, 1'b0);

        run_copy(32'h1000, 32'h2003, 6, 3, 2, 1'b1);
        if (wlog_a.size() > 0) check("t3_dst_aligned", wlog_a[0], 32'h2000);

        run_copy(32'h400, 32'h800, 8, 0, 5, 1'b0);

        run_copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1, 1, 1'b0);
        check("t5_nreads", 32'(rlog.size()), 32'd3);
        if (rlog.size() == 3) begin
            check("t5_r0", rlog[0], 32'hFFFF_FFF8);
            check("t5_r1", rlog[1], 32'hFFFF_FFFC);
            check("t5_r2", rlog[2], 32'h0000_0000);
        end
        if (wlog_a.size() == 3) check("t5_wwrap", wlog_a[1], 32'h0000_0000);

        // Abort with reads in flight; their responses arrive after reset.
        stall_cfg = 0;
        lat_cfg   = 8;
        setup_model(32'h3000, 32'h5000, 6);
        src_addr = 32'h3000;
        dst_addr = 32'h5000;
        len_b    = 16'd6;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (inflight < 2 && n < 50) begin
            tick();
            n++;
        end
        check("t6_two_inflight", 32'(inflight), 32'd2);
        d0     = done_cnt;
        rst    = 1'b1;
        mon_en = 1'b0;
        tick();
        check("t6_req_low", 32'(bus_req), 32'h0);
        check("t6_busy_low", 32'(busy), 32'h0);
        rst = 1'b0;
        n = 0;
        while (rq.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("t6_strays_delivered", 32'(rq.size()), 32'h0);
        repeat (3) tick();
        check("t6_no_done", 32'(done_cnt - d0), 32'h0);
        check("t6_idle_req", 32'(bus_req), 32'h0);
        run_copy(32'h3000, 32'h6000, 5, 1, 2, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_copy($urandom, $urandom, $urandom_range(1, 12), $urandom_range(0, 3),
                     $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
